ex_mem_buffer: RTL and testbench
================================

EX_MEM_BUFFER -- requirements
Module: ex_mem_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width of the result, store data and redirect PC.
REQ-002 SHALL have parameter REG_W, default 5, width of the destination-register index.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, the execute stage presents an instruction.
REQ-006 SHALL have port in_ready, output, 1, the buffer can accept an instruction this cycle.
REQ-007 SHALL have port in_alu_out, input, DATA_W, the ALU result, or the next PC for a control-flow op.
REQ-008 SHALL have port in_link, input, DATA_W, PC+4 of the instruction.
REQ-009 SHALL have port in_store_data, input, DATA_W, rs2 value used by stores.
REQ-010 SHALL have port in_rd, input, REG_W, destination register index.
REQ-011 SHALL have port in_ctl, input, 4, the control bits {reg_write, mem_read, mem_write, is_ctrl_flow}.
REQ-012 SHALL have port flush, input, 1, discard all buffered and in-flight entries.
REQ-013 SHALL have port out_valid, output, 1, the head entry is valid.
REQ-014 SHALL have port out_ready, input, 1, the memory stage consumes the head entry.
REQ-015 SHALL have port out_result, output, DATA_W, the head entry's result.
REQ-016 SHALL have ports out_store_data (DATA_W), out_rd (REG_W) and out_ctl (3), all outputs, carrying the head entry's payload; out_ctl is {reg_write, mem_read, mem_write}.
REQ-017 SHALL have port redirect_valid, output, 1, a one-cycle pulse for a control-flow op.
REQ-018 SHALL have port redirect_pc, output, DATA_W, the target PC of that pulse.

Function
REQ-019 SHALL be a 2-entry in-order buffer with states EMPTY, ONE and FULL.
REQ-020 SHALL drive in_ready = (state != FULL); in_ready SHALL NOT depend on out_ready.
REQ-021 SHALL accept an entry when in_valid && in_ready && !flush.
REQ-022 SHALL pop the head entry when out_valid && out_ready && !flush.
REQ-023 SHALL make the following transitions: EMPTY+push->ONE; ONE+push only->FULL; ONE+pop only->EMPTY; ONE+push+pop->ONE, with the new entry at the head next cycle; FULL+pop->ONE.
REQ-024 SHALL drive out_valid = (state != EMPTY), with the out_* payload taken from the head entry; out_* is don't-care when out_valid=0.
REQ-025 SHALL keep the head payload stable while out_valid && !out_ready.
REQ-026 SHALL store out_result = in_link when is_ctrl_flow=1, otherwise in_alu_out.
REQ-027 SHALL, when an accepted entry has is_ctrl_flow=1, set redirect_valid=1 for exactly the next cycle with redirect_pc = in_alu_out; redirect_valid is 0 otherwise.
REQ-028 SHALL give flush priority: the next state is EMPTY, the same-cycle input is dropped, no pop is counted, and no redirect is raised.
REQ-029 SHALL pass the data fields through untouched, with no arithmetic and no sign changes.

Reset
REQ-030 SHALL, on rst_n=0, immediately force state=EMPTY, out_valid=0, redirect_valid=0 and redirect_pc=0; in_ready SHALL be 1 while in reset.
REQ-031 SHALL lose any entry held when reset is asserted mid-operation, with no output pulse.
REQ-032 SHALL leave payload storage unreset.

Structure
REQ-033 SHALL place the control-bit index constants and the payload struct {result, store_data, rd, ctl} in a shared package, ex_mem_pkg.
REQ-034 SHALL contain one sub-module, skid_fifo2: a generic 2-entry FIFO with push/pop and a flush input.

Verification
REQ-035 SHALL cover a single add: in_alu_out=5 with reg_write, out_ready=1 -> out_valid next cycle with out_result=5, then EMPTY.
REQ-036 SHALL cover backpressure: out_ready=0 with pushes of 1, 2, 3 -> in_ready=0 after 2; then out_ready=1 -> outputs 1 then 2, and 3 is accepted once in_ready returns.
REQ-037 SHALL cover a taken control-flow op: in_alu_out=0x100, in_link=0x24 -> redirect_valid=1 for one cycle with redirect_pc=0x100, and out_result=0x24.
REQ-038 SHALL cover a simultaneous push and pop in ONE: head 7, push 8 -> next cycle out_result=8, state ONE.
REQ-039 SHALL cover flush while FULL with in_valid=1 -> next cycle out_valid=0 and no redirect.
REQ-040 SHALL cover rst_n asserted mid-cycle while FULL -> out_valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ex_mem_pkg.sv
// Shared definitions for the EX/MEM pipeline buffer: control-bit positions,
// FIFO occupancy states and the payload record carried through the buffer.
package ex_mem_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_W_DEF  = 5;

  // Bit positions within the 4-bit execute-stage control word
  localparam int CTL_REG_WRITE    = 3;
  localparam int CTL_MEM_READ     = 2;
  localparam int CTL_MEM_WRITE    = 1;
  localparam int CTL_IS_CTRL_FLOW = 0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } fifo_state_t;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] result;
    logic [DATA_W_DEF-1:0] store_data;
    logic [REG_W_DEF-1:0]  rd;
    logic [2:0]            ctl;
  } payload_t;

  function automatic logic [2:0] mem_ctl(input logic [3:0] ctl);
    return {ctl[CTL_REG_WRITE], ctl[CTL_MEM_READ], ctl[CTL_MEM_WRITE]};
  endfunction

endpackage

// File: rtl/ex_mem_buffer_skid_fifo2.sv
// Generic two-entry in-order FIFO; slot0 is always the head, flush empties it.
module skid_fifo2
  import ex_mem_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] head_data,
  output logic         empty,
  output logic         full
);

  fifo_state_t  state_reg, state_next;
  logic [W-1:0] slot0_reg, slot1_reg;
  logic         do_push, do_pop;

  assign do_push   = push && (state_reg != FULL) && !flush;
  assign do_pop    = pop && (state_reg != EMPTY) && !flush;
  assign empty     = (state_reg == EMPTY);
  assign full      = (state_reg == FULL);
  assign head_data = slot0_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= EMPTY;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = EMPTY;
    end else begin
      case (state_reg)
        EMPTY:   if (do_push) state_next = ONE;
        ONE: begin
          if (do_push && !do_pop)      state_next = FULL;
          else if (do_pop && !do_push) state_next = EMPTY;
        end
        FULL:    if (do_pop) state_next = ONE;
        default: state_next = EMPTY;
      endcase
    end
  end

  // Storage is deliberately unreset; validity lives entirely in state_reg
  always_ff @(posedge clk) begin
    case (state_reg)
      EMPTY: if (do_push) slot0_reg <= push_data;
      ONE: begin
        if (do_push && do_pop) slot0_reg <= push_data;
        else if (do_push)      slot1_reg <= push_data;
      end
      FULL:  if (do_pop) slot0_reg <= slot1_reg;
      default: ;
    endcase
  end

endmodule

// File: rtl/ex_mem_buffer.sv
// EX/MEM pipeline buffer: two-entry in-order queue plus a one-cycle branch
// redirect pulse for accepted control-flow instructions.
module ex_mem_buffer
  import ex_mem_pkg::*;
#(
  // Payload layout comes from ex_mem_pkg::payload_t; overrides must match it
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_alu_out,
  input  logic [DATA_W-1:0] in_link,
  input  logic [DATA_W-1:0] in_store_data,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [3:0]        in_ctl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [DATA_W-1:0] out_store_data,
  output logic [REG_W-1:0]  out_rd,
  output logic [2:0]        out_ctl,
  output logic              redirect_valid,
  output logic [DATA_W-1:0] redirect_pc
);

  payload_t push_payload, head_payload;
  logic     empty, full, accept;

  always_comb begin
    push_payload.result     = in_ctl[CTL_IS_CTRL_FLOW] ? in_link : in_alu_out;
    push_payload.store_data = in_store_data;
    push_payload.rd         = in_rd;
    push_payload.ctl        = mem_ctl(in_ctl);
  end

  skid_fifo2 #(.W($bits(payload_t))) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (in_valid),
    .pop       (out_ready),
    .flush     (flush),
    .push_data (push_payload),
    .head_data (head_payload),
    .empty     (empty),
    .full      (full)
  );

  assign in_ready       = !full;
  assign out_valid      = !empty;
  assign accept         = in_valid && in_ready && !flush;
  assign out_result     = head_payload.result;
  assign out_store_data = head_payload.store_data;
  assign out_rd         = head_payload.rd;
  assign out_ctl        = head_payload.ctl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      redirect_valid <= accept && in_ctl[CTL_IS_CTRL_FLOW];
      if (accept && in_ctl[CTL_IS_CTRL_FLOW]) redirect_pc <= in_alu_out;
    end
  end

endmodule

// File: tb/tb_ex_mem_buffer.sv
// Directed table-driven bench for ex_mem_buffer plus hand-written reset sequences.
module tb_ex_mem_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, flush, out_valid, out_ready, redirect_valid;
  logic [31:0] in_alu_out, in_link, in_store_data, out_result, out_store_data, redirect_pc;
  logic [4:0]  in_rd, out_rd;
  logic [3:0]  in_ctl;
  logic [2:0]  out_ctl;

  int checks = 0;
  int errors = 0;

  ex_mem_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_out(in_alu_out), .in_link(in_link), .in_store_data(in_store_data),
    .in_rd(in_rd), .in_ctl(in_ctl), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_store_data(out_store_data),
    .out_rd(out_rd), .out_ctl(out_ctl),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] alu, link, sd;
    logic [4:0]  rd;
    logic [3:0]  ctl;
    logic        fl, ordy;
    logic        e_ir, e_ov;
    logic [31:0] e_res, e_sd;
    logic [4:0]  e_rd;
    logic [2:0]  e_ctl;
    logic        e_rv;
    logic [31:0] e_rpc;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs[NV];

  function automatic vec_t mk(logic iv, logic [31:0] alu, logic [31:0] link, logic [31:0] sd,
                              logic [4:0] rd, logic [3:0] ctl, logic fl, logic ordy,
                              logic e_ir, logic e_ov, logic [31:0] e_res, logic [31:0] e_sd,
                              logic [4:0] e_rd, logic [2:0] e_ctl, logic e_rv, logic [31:0] e_rpc);
    vec_t v;
    v.iv = iv; v.alu = alu; v.link = link; v.sd = sd; v.rd = rd; v.ctl = ctl;
    v.fl = fl; v.ordy = ordy; v.e_ir = e_ir; v.e_ov = e_ov; v.e_res = e_res;
    v.e_sd = e_sd; v.e_rd = e_rd; v.e_ctl = e_ctl; v.e_rv = e_rv; v.e_rpc = e_rpc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [31:0] alu, input logic [31:0] link,
                       input logic [31:0] sd, input logic [4:0] rd, input logic [3:0] ctl,
                       input logic fl, input logic ordy);
    in_valid = iv; in_alu_out = alu; in_link = link; in_store_data = sd;
    in_rd = rd; in_ctl = ctl; flush = fl; out_ready = ordy;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // Row = inputs for one cycle and the outputs expected before that cycle's edge
    vecs[0]  = mk(1, 5, 4, 'hA5, 3, 4'b1000, 0, 1,  1, 0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, 1,           1, 1, 5, 'hA5, 3, 3'b100, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0,           1, 0, 0, 0, 0, 0, 0, 0);
    vecs[3]  = mk(1, 1, 8, 'hB1, 1, 4'b1000, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0);
    vecs[4]  = mk(1, 2, 12, 'hB2, 2, 4'b0010, 0, 0, 1, 1, 1, 'hB1, 1, 3'b100, 0, 0);
    vecs[5]  = mk(1, 3, 16, 'hB3, 3, 4'b0100, 0, 0, 0, 1, 1, 'hB1, 1, 3'b100, 0, 0);
    vecs[6]  = mk(1, 3, 16, 'hB3, 3, 4'b0100, 0, 1, 0, 1, 1, 'hB1, 1, 3'b100, 0, 0);
    vecs[7]  = mk(1, 3, 16, 'hB3, 3, 4'b0100, 0, 1, 1, 1, 2, 'hB2, 2, 3'b001, 0, 0);
    vecs[8]  = mk(0, 0, 0, 0, 0, 0, 0, 1,           1, 1, 3, 'hB3, 3, 3'b010, 0, 0);
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0,           1, 0, 0, 0, 0, 0, 0, 0);
    vecs[10] = mk(1, 'h100, 'h24, 'hC0, 1, 4'b1001, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 0,           1, 1, 'h24, 'hC0, 1, 3'b100, 1, 'h100);
    vecs[12] = mk(0, 0, 0, 0, 0, 0, 0, 1,           1, 1, 'h24, 'hC0, 1, 3'b100, 0, 0);
    vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 0,           1, 0, 0, 0, 0, 0, 0, 0);
    vecs[14] = mk(1, 7, 0, 'hD7, 7, 4'b1000, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0);
    vecs[15] = mk(1, 8, 0, 'hD8, 8, 4'b1000, 0, 1,  1, 1, 7, 'hD7, 7, 3'b100, 0, 0);
    vecs[16] = mk(0, 0, 0, 0, 0, 0, 0, 0,           1, 1, 8, 'hD8, 8, 3'b100, 0, 0);
    vecs[17] = mk(0, 0, 0, 0, 0, 0, 0, 1,           1, 1, 8, 'hD8, 8, 3'b100, 0, 0);
    vecs[18] = mk(0, 0, 0, 0, 0, 0, 0, 0,           1, 0, 0, 0, 0, 0, 0, 0);
    vecs[19] = mk(1, 9, 0, 'hE9, 9, 4'b1000, 0, 0,  1, 0, 0, 0, 0, 0, 0, 0);
    vecs[20] = mk(1, 10, 0, 'hEA, 10, 4'b1000, 0, 0, 1, 1, 9, 'hE9, 9, 3'b100, 0, 0);
    vecs[21] = mk(1, 'h200, 'h44, 0, 1, 4'b0001, 1, 1, 0, 1, 9, 'hE9, 9, 3'b100, 0, 0);
    vecs[22] = mk(0, 0, 0, 0, 0, 0, 0, 1,           1, 0, 0, 0, 0, 0, 0, 0);
    vecs[23] = mk(0, 0, 0, 0, 0, 0, 0, 0,           1, 0, 0, 0, 0, 0, 0, 0);

    #1;
    chk("reset in_ready", in_ready, 1);
    chk("reset out_valid", out_valid, 0);
    chk("reset redirect_valid", redirect_valid, 0);
    chk("reset redirect_pc", redirect_pc, 0);
    $display("reset: in_ready=%0b out_valid=%0b redirect_valid=%0b", in_ready, out_valid, redirect_valid);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i].iv, vecs[i].alu, vecs[i].link, vecs[i].sd, vecs[i].rd, vecs[i].ctl,
            vecs[i].fl, vecs[i].ordy);
      #1;
      $display("row %0d: in_valid=%0b flush=%0b out_ready=%0b -> in_ready=%0b out_valid=%0b result=0x%0h redirect=%0b/0x%0h",
               i, in_valid, flush, out_ready, in_ready, out_valid, out_result, redirect_valid, redirect_pc);
      chk($sformatf("row%0d in_ready", i), in_ready, vecs[i].e_ir);
      chk($sformatf("row%0d out_valid", i), out_valid, vecs[i].e_ov);
      chk($sformatf("row%0d redirect_valid", i), redirect_valid, vecs[i].e_rv);
      if (vecs[i].e_rv) chk($sformatf("row%0d redirect_pc", i), redirect_pc, vecs[i].e_rpc);
      if (vecs[i].e_ov) begin
        chk($sformatf("row%0d out_result", i), out_result, vecs[i].e_res);
        chk($sformatf("row%0d out_store_data", i), out_store_data, vecs[i].e_sd);
        chk($sformatf("row%0d out_rd", i), {27'd0, out_rd}, {27'd0, vecs[i].e_rd});
        chk($sformatf("row%0d out_ctl", i), {29'd0, out_ctl}, {29'd0, vecs[i].e_ctl});
      end
    end

    // Fill to FULL with a control-flow op second, then reset mid-cycle
    @(negedge clk);
    drive(1, 'h11, 0, 0, 4, 4'b1000, 0, 0);
    @(negedge clk);
    drive(1, 'h300, 'h50, 0, 5, 4'b1001, 0, 0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("prefill out_valid", out_valid, 1);
    chk("prefill in_ready", in_ready, 0);
    chk("prefill redirect_valid", redirect_valid, 1);
    chk("prefill redirect_pc", redirect_pc, 'h300);
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset: out_valid=%0b in_ready=%0b redirect_valid=%0b", out_valid, in_ready, redirect_valid);
    chk("async reset out_valid", out_valid, 0);
    chk("async reset in_ready", in_ready, 1);
    chk("async reset redirect_valid", redirect_valid, 0);
    chk("async reset redirect_pc", redirect_pc, 0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    #1;
    $display("post reset: out_valid=%0b redirect_valid=%0b", out_valid, redirect_valid);
    chk("post reset out_valid", out_valid, 0);
    chk("post reset redirect_valid", redirect_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
